// File: rtl/act_pkg.sv
// Shared constants and helpers for the piecewise-linear activation unit.
// Defining ACT_LUT_INTERP_EN enables interpolation; otherwise the unit outputs the step value.
package act_pkg;

  localparam int ACT_IN_W   = 8;
  localparam int ACT_ADDR_W = 4;
  localparam int ACT_LUT_W  = 8;
  localparam int ACT_OUT_W  = 8;

  // Successor segment: the last negative segment wraps to entry 0,
  // the top positive segment saturates on itself.
  function automatic int next_idx(int addr, int addr_w);
    int last;
    int top_pos;
    last    = (1 << addr_w) - 1;
    top_pos = (1 << (addr_w - 1)) - 1;
    if (addr == last)    return 0;
    if (addr == top_pos) return addr;
    return addr + 1;
  endfunction

  function automatic int interp_y(int base, int nxt, int frac, int frac_w);
    int prod;
    prod = (nxt - base) * frac;
    return base + (prod >>> frac_w);
  endfunction

endpackage

// File: rtl/act_lut_regfile.sv
// Runtime-writable activation table: one write port, combinational base/next reads.
// The next read port exists only when ACT_LUT_INTERP_EN is defined.
module act_lut_regfile
  import act_pkg::*;
#(
  parameter int ADDR_W = ACT_ADDR_W,
  parameter int LUT_W  = ACT_LUT_W
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       waddr_i,
  input  logic [LUT_W-1:0]        wdata_i,
  input  logic [ADDR_W-1:0]       raddr_i,
  output logic signed [LUT_W-1:0] base_o
`ifdef ACT_LUT_INTERP_EN
  ,
  output logic signed [LUT_W-1:0] next_o
`endif
);

  // Contents deliberately survive reset.
  logic [LUT_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign base_o = mem_q[raddr_i];

`ifdef ACT_LUT_INTERP_EN
  logic [ADDR_W-1:0] nidx;
  assign nidx   = ADDR_W'(next_idx(int'(raddr_i), ADDR_W));
  assign next_o = mem_q[nidx];
`endif

endmodule

// File: rtl/act_lut_interp.sv
// Three-stage LUT activation: S1 table read, S2 diff*frac, S3 add into out_y.
// ACT_LUT_INTERP_EN selects interpolation; undefined gives a step function with equal latency.
module act_lut_interp
  import act_pkg::*;
#(
  parameter int IN_W   = ACT_IN_W,
  parameter int ADDR_W = ACT_ADDR_W,
  parameter int LUT_W  = ACT_LUT_W,
  parameter int OUT_W  = ACT_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_y,
  input  logic              lut_we,
  input  logic [ADDR_W-1:0] lut_waddr,
  input  logic [LUT_W-1:0]  lut_wdata
);

  localparam int FRAC_W = IN_W - ADDR_W;
  localparam int PW     = LUT_W + 1 + FRAC_W;
  localparam int STAGES = 3;

  logic              en;
  logic [STAGES:1]   vld_q;
  logic [ADDR_W-1:0] addr_s;
  logic signed [LUT_W-1:0] base_s, base1_q, base2_q, y_d;
  logic [OUT_W-1:0]  out_y_q, out_y_d;

  // One enable stalls the whole pipe so nothing is dropped under back-pressure.
  assign en        = !vld_q[STAGES] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES];
  assign out_y     = out_y_q;
  assign addr_s    = in_x[IN_W-1 -: ADDR_W];

  always_ff @(posedge clk) begin
    if (rst)     vld_q <= '0;
    else if (en) vld_q <= {vld_q[STAGES-1:1], in_valid};
  end

`ifdef ACT_LUT_INTERP_EN
  logic signed [LUT_W-1:0] next_s, next1_q;
  logic [FRAC_W-1:0]       frac1_q;
  logic signed [LUT_W:0]   diff_d;
  logic signed [PW-1:0]    prod_d, prod2_q;

  act_lut_regfile #(.ADDR_W(ADDR_W), .LUT_W(LUT_W)) u_lut (
    .clk_i(clk), .we_i(lut_we), .waddr_i(lut_waddr), .wdata_i(lut_wdata),
    .raddr_i(addr_s), .base_o(base_s), .next_o(next_s)
  );

  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      base1_q <= base_s;
      next1_q <= next_s;
      frac1_q <= in_x[FRAC_W-1:0];
    end
    if (en && vld_q[1]) begin
      base2_q <= base1_q;
      prod2_q <= prod_d;
    end
  end

  assign diff_d = (LUT_W+1)'(next1_q) - (LUT_W+1)'(base1_q);
  assign prod_d = PW'(diff_d) * PW'($signed({1'b0, frac1_q}));
  // Floor shift keeps the result between base and next, so LUT_W bits suffice.
  assign y_d    = base2_q + LUT_W'(prod2_q >>> FRAC_W);
`else
  logic unused_frac;
  assign unused_frac = ^in_x[FRAC_W-1:0];

  act_lut_regfile #(.ADDR_W(ADDR_W), .LUT_W(LUT_W)) u_lut (
    .clk_i(clk), .we_i(lut_we), .waddr_i(lut_waddr), .wdata_i(lut_wdata),
    .raddr_i(addr_s), .base_o(base_s)
  );

  always_ff @(posedge clk) begin
    if (en && in_valid) base1_q <= base_s;
    if (en && vld_q[1]) base2_q <= base1_q;
  end

  assign y_d = base2_q;
`endif

  assign out_y_d = OUT_W'(y_d);

  always_ff @(posedge clk) begin
    if (rst)                out_y_q <= '0;
    else if (en && vld_q[2]) out_y_q <= out_y_d;
  end

endmodule

// File: tb/tb_act_lut_interp.sv
// Directed bench for act_lut_interp; expectations follow ACT_LUT_INTERP_EN.
module tb_act_lut_interp;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, lut_we;
  logic [7:0] in_x, out_y, lut_wdata;
  logic [3:0] lut_waddr;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  act_lut_interp dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata)
  );

  function automatic logic [31:0] sx(logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample, check it emerges exactly three edges after acceptance.
  task automatic run1(string tag, logic [7:0] x, int exp);
    in_valid = 1'b1;
    in_x     = x;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    lut_we   = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_lat2"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_vld"}, 32'(out_valid), 1);
    chk({tag, "_y"}, sx(out_y), exp);
    tick();
  endtask

  int tbl[16] = '{0, 12, 15, 15, 15, 15, 15, 15, -15, -15, -15, -15, -15, -15, -15, -12};

`ifdef ACT_LUT_INTERP_EN
  localparam int E08 = 6,  E18 = 13, E88 = -15, E7F = 15, EF8 = -6,  EF0 = -12;
`else
  localparam int E08 = 0,  E18 = 12, E88 = -15, E7F = 15, EF8 = -12, EF0 = -12;
`endif

  int         xs[8] = '{8'h00, 8'h10, 8'hF0, 8'h20, 8'h80, 8'h00, 8'hF0, 8'h10};
  int         ys[8] = '{0, 12, -12, 15, -15, 0, -12, 12};
  int         sent, got;
  bit         prev_stall;
  logic [7:0] prev_y;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_y", sx(out_y), 0);
    chk("rst_rdy", 32'(in_ready), 1);

    for (int i = 0; i < 16; i++) begin
      lut_we = 1'b1; lut_waddr = 4'(i); lut_wdata = 8'(tbl[i]);
      tick();
    end
    lut_we = 1'b0;
    chk("idle_vld", 32'(out_valid), 0);

    run1("x08", 8'h08, E08);
    run1("x18", 8'h18, E18);
    run1("x88", 8'h88, E88);
    run1("x7F", 8'h7F, E7F);
    run1("xF8", 8'hF8, EF8);
    run1("xF0", 8'hF0, EF0);

    // Back-pressure: out_ready low in cycles 4..7 of the stream.
    sent = 0; got = 0; prev_stall = 1'b0; prev_y = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (sent < 8);
      if (sent < 8) in_x = 8'(xs[sent]);
      #1;
      if (prev_stall) begin
        chk("bp_hold_y", 32'(out_y), 32'(prev_y));
        chk("bp_hold_vld", 32'(out_valid), 1);
      end
      if (c >= 4 && c <= 7) chk("bp_rdy_low", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_y%0d", got), sx(out_y), ys[got]);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got, 8);
    tick();
    chk("bp_nodup", 32'(out_valid), 0);

    // Write to lut[1] in the acceptance cycle: the read sees the old entry.
    lut_we = 1'b1; lut_waddr = 4'd1; lut_wdata = 8'd4;
    run1("haz_old", 8'h10, 12);
    run1("haz_new", 8'h10, 4);

    // Reset with samples in flight.
    in_valid = 1'b1; in_x = 8'h00; tick();
    in_x = 8'h10; tick();
    in_x = 8'hF0; tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    chk("mrst_vld", 32'(out_valid), 0);
    chk("mrst_y", sx(out_y), 0);
    chk("mrst_rdy", 32'(in_ready), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mrst_stale", 32'(out_valid), 0);
    end
    run1("post_rst", 8'h20, 15);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/act_lut_interp.md
# act_lut_interp

Parametrised piecewise-linear activation unit for the fixed-point neural-network datapath. It takes a signed fixed-point pre-activation and uses its upper bits to index a runtime-writable lookup table. The lower bits linearly interpolate between the indexed entry and its successor. It sits between a layer's accumulator/bias stage and the next layer's input, replacing fixed ROM-initialised activation tables with a loadable, pipelined, flow-controlled block.

## Interface
- IN_W, 8, width of signed input x
- ADDR_W, 4, LUT index width; table depth 2^ADDR_W; FRAC_W = IN_W - ADDR_W (must be ≥ 1)
- LUT_W, 8, signed LUT entry width
- OUT_W, 8, signed output width; OUT_W ≥ LUT_W, result sign-extended
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts sample this cycle
- in_x  in  IN_W  signed two's-complement pre-activation
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  OUT_W  signed activation result
- lut_we  in  1  table write strobe
- lut_waddr  in  ADDR_W  table write index
- lut_wdata  in  LUT_W  signed table write data

## Operation
- Index split: addr = in_x[IN_W-1 -: ADDR_W] (signed order: 0 … 2^(A-1)-1 positive, 2^(A-1) … 2^A-1 negative); frac = low FRAC_W bits, unsigned.
- base = lut[addr]. next is selected as follows:
  - addr = all-ones (last negative segment): next = lut[0] (wrap toward zero).
  - addr = 2^(A-1)-1 (top positive segment): next = base (saturate).
  - otherwise: next = lut[addr+1].
- diff = next - base, signed LUT_W+1 bits.
- prod = diff * frac, signed LUT_W+1+FRAC_W bits.
- y = base + (prod >>> FRAC_W), using an arithmetic shift (floor rounding); the result lies between base and next, so no overflow occurs; it is sign-extended to OUT_W.
- Pipeline, three stages:
  - S1: split, LUT read of base/next, register frac.
  - S2: diff and multiply.
  - S3: add and register into out_y.
- Flow control:
  - Global advance enable en = !out_valid | out_ready.
  - in_ready = en.
  - Each stage valid bit shifts on en and holds otherwise (full stall, no bubbles lost).
- LUT writes:
  - Writes are independent of the handshake and commit at the clock edge.
  - An S1 read in the same cycle as a write to the same entry returns the old value.
  - Samples already past S1 are unaffected by later writes.
- Reset:
  - Clears all stage valids; out_valid = 0, out_y = 0.
  - in_ready = 1 in the first cycle after reset.
  - LUT contents are not reset and are retained across rst.
  - In-flight samples at reset are discarded and never appear at the output.

## Timing
- Latency: 3 cycles from an in_valid & in_ready edge to out_valid, with no stall.
- Throughput: 1 sample/cycle while out_ready = 1.
- out_y and out_valid are registered and stay stable while out_valid & !out_ready.
- A LUT write at edge t is visible to a sample accepted at edge t+1 or later.

## Configuration
- ACT_LUT_INTERP_EN defined: interpolation is active, as in Operation.
- ACT_LUT_INTERP_EN undefined:
  - y = base (step function); the next-selection, diff and multiply logic is removed.
  - Pipeline depth stays 3 cycles so latency and handshake are identical.

## Structure
- Shared package act_pkg holds:
  - Default parameter constants.
  - The interpolation function (base, next, frac → y).
  - The next-index wrap/saturate rule as a function, so the bench model reuses it.
- One sub-module, act_lut_regfile:
  - 2^ADDR_W × LUT_W register array.
  - One write port and two combinational read ports (base, next), with the wrap/saturate index logic inside.

## Test plan
All scenarios use defaults, with the LUT loaded to entries 0..15 = 0, 12, 15, 15, 15, 15, 15, 15, -15, -15, -15, -15, -15, -15, -15, -12.
- Interpolation:
  - x = 0x08 -> y = 6.
  - x = 0x18 -> y = 13.
  - x = 0x88 -> y = -15.
  - Each arrives exactly 3 cycles after acceptance.
- Boundaries:
  - x = 0x7F (saturate) -> y = 15.
  - x = 0xF8 (wrap to lut[0]) -> y = -6.
  - x = 0xF0 -> y = -12.
- Back-pressure: stream 8 samples with out_ready low for cycles 4–7 -> no loss or duplication, order preserved, out_y stable while stalled, in_ready low during the stall.
- Write hazard:
  - Write lut[1] = 4 in the same cycle as accepting x = 0x10 -> y = 12 (old value).
  - The next x = 0x10 -> y = 4.
- Reset mid-stream: assert rst with 3 samples in flight -> out_valid = 0 and out_y = 0 next cycle, no stale outputs, LUT unchanged (x = 0x20 -> 15 afterward).
- Build without ACT_LUT_INTERP_EN: x = 0x08 -> y = 0, x = 0xF8 -> y = -12, latency still 3.
